// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch and data access,
// one transaction in flight, data preferred but fetch forced after MAX_DATA_RUN data wins.
module riscv_mem_arbiter #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);
    state_t state, state_d;
    logic owner;
    logic we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0] run_cnt;
    logic pick_i, pick_d, issue, acc, done;
    always_comb begin
        state_d = state;
        pick_i = 1'b0;
        pick_d = 1'b0;
        case (state)
            IDLE: begin
                pick_i = i_req && (!d_req || run_cnt == RUN_MAX);
                pick_d = d_req && !pick_i;
                state_d = (i_req || d_req) ? ISSUE : IDLE;
            end
            ISSUE: state_d = m_ready ? WAIT : ISSUE;
            WAIT: state_d = m_rvalid ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end
    // owner: 0 = fetch, 1 = data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            run_cnt <= '0;
        end else begin
            state <= state_d;
            if (pick_i) begin
                owner <= 1'b0;
                we_q <= 1'b0;
                addr_q <= i_addr;
                wdata_q <= '0;
                run_cnt <= '0;
            end else if (pick_d) begin
                owner <= 1'b1;
                we_q <= d_we;
                addr_q <= d_addr;
                wdata_q <= d_wdata;
                run_cnt <= !i_req ? 4'd0 : (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 4'd1;
            end
        end
    end
    assign issue = state == ISSUE;
    assign acc = issue && m_ready;
    assign done = state == WAIT && m_rvalid;
    assign busy = state != IDLE;
    assign m_req = issue;
    assign m_we = issue && we_q;
    assign m_addr = issue ? addr_q : '0;
    assign m_wdata = issue ? wdata_q : '0;
    assign i_gnt = acc && !owner;
    assign d_gnt = acc && owner;
    assign i_rvalid = done && !owner;
    assign d_rvalid = done && owner;
    assign i_rdata = i_rvalid ? m_rdata : '0;
    assign d_rdata = d_rvalid ? m_rdata : '0;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed stimulus with a queue scoreboard checked by an
// independent output monitor; a small memory model answers the shared port.
module tb_riscv_mem_arbiter;
    logic clk = 1'b0, rst;
    logic i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic m_req, m_we, m_ready, m_rvalid, busy;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
    int vectors = 0, miscompares = 0;
    int stall = 0;
    logic spur = 1'b0, hold_rv = 1'b0;
    logic [31:0] cap_a = '0;
    logic cap_we = 1'b0;
    logic [3:0] evs;
    typedef struct {
        int kind;
        logic [31:0] a;
        logic we;
        logic [31:0] wd;
        logic [31:0] rd;
    } ev_t;
    ev_t q[$];

    riscv_mem_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    assign evs = {d_rvalid, i_rvalid, d_gnt, i_gnt};

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h100 ? 32'h00500093 : a ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic exp_ev(input int k, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [31:0] rd);
        ev_t e;
        e.kind = k; e.a = a; e.we = we; e.wd = wd; e.rd = rd;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_ctl"}, 32'({m_req, m_we, i_gnt, i_rvalid, d_gnt, d_rvalid, busy}), 32'h0);
        chk({n, "_m_addr"}, m_addr, 32'h0);
        chk({n, "_m_wdata"}, m_wdata, 32'h0);
        chk({n, "_i_rdata"}, i_rdata, 32'h0);
        chk({n, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    task automatic wait_ev(input int k, input string n);
        bit got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk); #2;
            got = evs[k];
        end
        if (!got) chk({n, "_timeout"}, 32'h0, 32'h1);
    endtask

    // memory model: accepts after `stall` cycles, responds one cycle after acceptance
    initial forever begin
        @(negedge clk); #1;
        if (m_req) begin
            m_ready = stall == 0;
            if (stall > 0) stall--;
            cap_a = m_addr;
            cap_we = m_we;
        end else m_ready = 1'b0;
        if (busy && !m_req && !hold_rv) begin
            m_rvalid = 1'b1;
            m_rdata = cap_we ? 32'h0 : mem(cap_a);
        end else begin
            m_rvalid = spur;
            m_rdata = spur ? 32'hBAD0BAD0 : 32'h0;
        end
    end

    initial forever begin
        ev_t e;
        @(negedge clk); #2;
        for (int k = 0; k < 4; k++) if (evs[k]) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected: event kind %0d observed, none expected at %0t", k, $time);
            end else begin
                e = q.pop_front();
                chk("ev_kind", k, e.kind);
                if (k < 2) begin
                    chk("gnt_m_addr", m_addr, e.a);
                    chk("gnt_m_we", 32'(m_we), 32'(e.we));
                    chk("gnt_m_wdata", m_wdata, e.wd);
                end else chk(k == 2 ? "i_rdata" : "d_rdata", k == 2 ? i_rdata : d_rdata, e.rd);
            end
        end
    end

    initial begin
        int reqc, gc, bad, rvc;
        bit got;
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0; spur = 1'b1;
        #2 chk_zero("reset0");
        repeat (2) @(negedge clk);
        #2 chk_zero("reset1");
        // single fetch straight out of reset
        @(negedge clk);
        rst = 1'b1; spur = 1'b0;
        exp_ev(0, 32'h100, 1'b0, 32'h0, 32'h0);
        exp_ev(2, 32'h0, 1'b0, 32'h0, 32'h00500093);
        @(negedge clk); #2;
        chk("c1_m_req", 32'(m_req), 32'h1);
        chk("c1_m_addr", m_addr, 32'h100);
        chk("c1_m_we", 32'(m_we), 32'h0);
        @(negedge clk); #2;
        chk("c2_i_rvalid", 32'(i_rvalid), 32'h1);
        chk("c2_i_rdata", i_rdata, 32'h00500093);
        @(negedge clk);
        i_req = 1'b0;
        #2 chk("c3_busy", 32'(busy), 32'h0);
        // store with three stall cycles
        @(negedge clk);
        stall = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        exp_ev(1, 32'h2000, 1'b1, 32'hDEADBEEF, 32'h0);
        exp_ev(3, 32'h0, 1'b0, 32'h0, 32'h0);
        reqc = 0; gc = 0; bad = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk); #2;
            if (m_req) begin
                reqc++;
                if (m_addr !== 32'h2000 || m_we !== 1'b1 || m_wdata !== 32'hDEADBEEF) bad++;
            end
            if (d_gnt) gc++;
            got = d_rvalid;
        end
        chk("st_ack", 32'(got), 32'h1);
        chk("st_req_cycles", reqc, 4);
        chk("st_gnt_pulses", gc, 1);
        chk("st_unstable", bad, 0);
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        // spurious responses in IDLE then in ISSUE
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk); #2;
            chk("sp_idle_busy", 32'({busy, m_req}), 32'h0);
        end
        stall = 5;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h400;
        exp_ev(0, 32'h400, 1'b0, 32'h0, 32'h0);
        exp_ev(2, 32'h0, 1'b0, 32'h0, 32'h5A5A0400);
        repeat (3) begin
            @(negedge clk); #2;
            chk("sp_issue_hold", 32'({m_req, busy, i_rvalid}), 32'h6);
        end
        spur = 1'b0;
        wait_ev(2, "sp_fetch");
        @(negedge clk);
        i_req = 1'b0;
        // reset asserted between edges while waiting on the response
        hold_rv = 1'b1;
        stall = 0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h500;
        exp_ev(0, 32'h500, 1'b0, 32'h0, 32'h0);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk); #2;
            got = busy && !m_req;
        end
        chk("rs_reach_wait", 32'(got), 32'h1);
        #1;
        rst = 1'b0; i_req = 1'b0; spur = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
        #1 chk_zero("rs_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk); #2;
            chk("rs_stale_busy", 32'(busy), 32'h0);
        end
        spur = 1'b0; hold_rv = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h100;
        exp_ev(0, 32'h100, 1'b0, 32'h0, 32'h0);
        exp_ev(2, 32'h0, 1'b0, 32'h0, 32'h00500093);
        wait_ev(2, "rs_fetch");
        @(negedge clk);
        i_req = 1'b0;
        // contention: both held, fetch forced after every four data wins
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'h11111111;
        for (int k = 0; k < 10; k++)
            if (k % 5 == 4) begin
                exp_ev(0, 32'h200, 1'b0, 32'h0, 32'h0);
                exp_ev(2, 32'h0, 1'b0, 32'h0, 32'h5A5A0200);
            end else begin
                exp_ev(1, 32'h3000, 1'b0, 32'h11111111, 32'h0);
                exp_ev(3, 32'h0, 1'b0, 32'h0, 32'h5A5A3000);
            end
        rvc = 0;
        for (int c = 0; c < 200 && rvc < 10; c++) begin
            @(negedge clk); #2;
            if (i_rvalid || d_rvalid) rvc++;
        end
        chk("ct_completions", rvc, 10);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        #3 chk("sb_leftover", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
